arb_req_queue4: RTL and testbench

// - Upstream feeder for the 4-way rotating priority selector.
// - Buffers requests from 4 independent sources in per-source FIFOs and drives req[3:0] to the selector.
// - Takes the selector's one-hot grant back in the same cycle and pops the granted head into a single output register.
// - Output register presents data, plus source ID, to the shared downstream resource via valid/ready.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/arb_req_queue4_if.sv | 36 +++
 rtl/arb_src_fifo.sv | 64 ++++++
 rtl/arb_req_queue4.sv | 88 ++++++++
 tb/tb_arb_req_queue4.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-source request queue that feeds the rotating
// priority selector.
//   NUM_REQ   : number of request sources
//   SRC_W     : width of a source index
//   req_vec_t : one bit per source (requests, grants, per-source flags)
//   src_idx_t : encoded source index
//   lowest_idx: encodes the lowest set bit of a source vector
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [SRC_W-1:0]   src_idx_t;

  // Walking from the top down leaves the lowest set bit as the result, so a
  // multi-hot vector resolves to its lowest-numbered source.
  function automatic src_idx_t lowest_idx(input req_vec_t vec);
    lowest_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) lowest_idx = src_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/arb_req_queue4_if.sv
// Bundle of every handshake signal of arb_req_queue4.
//   in_valid/in_data/in_ready : per-source push side (source i at
//                               in_data[i*DATA_W +: DATA_W])
//   arb_req/arb_en/arb_gnt    : link to the rotating priority selector
//   out_valid/out_data/out_src/out_ready : output register towards the
//                               shared downstream resource
// Modports: slave = the queue itself, master = whatever surrounds it.
interface arb_req_queue4_if #(
  parameter int DATA_W = 8
);
  import arb_pkg::*;

  req_vec_t                    in_valid;
  logic [NUM_REQ*DATA_W-1:0]   in_data;
  req_vec_t                    in_ready;

  req_vec_t                    arb_req;
  logic                        arb_en;
  req_vec_t                    arb_gnt;

  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  src_idx_t                    out_src;
  logic                        out_ready;

  modport slave (
    input  in_valid, in_data, arb_gnt, out_ready,
    output in_ready, arb_req, arb_en, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, arb_gnt, out_ready,
    input  in_ready, arb_req, arb_en, out_valid, out_data, out_src
  );

endinterface

// File: rtl/arb_src_fifo.sv
// Per-source FIFO, DEPTH entries of DATA_W bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored while full)
//   push_data  : payload to store
//   pop        : drop the head entry (ignored while empty)
//   full/empty : derived from the registered occupancy count
//   head       : oldest stored entry, valid while !empty
// A push and a pop in the same cycle both take effect and leave the count
// unchanged. DEPTH must be a power of two so pointers wrap naturally.
module arb_src_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it has been
  // written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/arb_req_queue4.sv
// Upstream feeder for the 4-way rotating priority selector.
//   CLK   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset, discards all queued/output data
//   bus   : arb_req_queue4_if.slave carrying the per-source push ports, the
//           selector request/enable/grant link and the output valid/ready
//           register (data plus source index).
// Each source owns a small FIFO. A non-empty FIFO requests the selector only
// while the output slot can take a new payload; the same-cycle grant pops
// that FIFO's head straight into the output register.
module arb_req_queue4
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic               CLK,
  input  logic               rst_n,
  arb_req_queue4_if.slave    bus
);

  req_vec_t          full;
  req_vec_t          empty;
  req_vec_t          pop;
  req_vec_t          accepted;
  logic [DATA_W-1:0] head [NUM_REQ];
  logic              slot_free;
  logic              grant_any;
  src_idx_t          grant_idx;

  // The slot can take a payload when it is empty or draining this cycle.
  // Withholding requests otherwise means a grant never lands on a stall.
  assign slot_free   = ~bus.out_valid | bus.out_ready;
  assign bus.arb_req = ~empty & {NUM_REQ{slot_free}};
  assign bus.arb_en  = |bus.arb_req;
  assign bus.in_ready = ~full;

  // Grant bits without a matching request are dropped here, which also
  // covers any grant seen while arb_en is low.
  assign accepted  = bus.arb_gnt & bus.arb_req;
  assign grant_any = |accepted;
  assign grant_idx = lowest_idx(accepted);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop = '0;
    if (grant_any) pop[grant_idx] = 1'b1;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    arb_src_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (CLK),
      .rst_n     (rst_n),
      .push      (bus.in_valid[i]),
      .push_data (bus.in_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head[i])
    );
  end

  // A new grant wins over the drain, so a transfer plus a grant in one
  // cycle reloads the slot and keeps out_valid high.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else if (grant_any) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= head[grant_idx];
      bus.out_src   <= grant_idx;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Two requesting sources granted at once is a selector bug; the decode
  // above still resolves it to the lowest source.
  a_gnt_onehot: assert property (@(posedge CLK) disable iff (!rst_n)
    $onehot0(accepted))
    else $error("arb_req_queue4: multi-hot grant %b", bus.arb_gnt);

endmodule

// File: tb/tb_arb_req_queue4.sv
// Bench for arb_req_queue4: a rotating priority selector stands in for the
// paired rps4, a queue-based model predicts every output each cycle, and the
// directed scenarios add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_arb_req_queue4;
  import arb_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_req_queue4_if #(.DATA_W(DATA_W)) bus ();

  arb_req_queue4 #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- selector stand-in (rotating priority) ----------------
  logic     force_en;
  req_vec_t force_gnt;
  req_vec_t sel_gnt;
  src_idx_t rr_last;

  always_comb begin
    sel_gnt = '0;
    if (bus.arb_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (sel_gnt == '0 && bus.arb_req[(int'(rr_last) + k) % NUM_REQ])
          sel_gnt[(int'(rr_last) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

  assign bus.arb_gnt = force_en ? force_gnt : sel_gnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last <= src_idx_t'(NUM_REQ - 1);
    else if (!force_en) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (sel_gnt[k]) rr_last <= src_idx_t'(k);
    end
  end

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] q [NUM_REQ][$];
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  src_idx_t          m_src;
  logic [9:0]        xlog [$];

  task automatic model_cycle();
    req_vec_t m_rdy, m_req, m_acc;
    logic     m_free;
    int       pop_k;
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) q[i].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
    end
    m_free = !m_valid || bus.out_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_rdy[i] = (q[i].size() < DEPTH);
      m_req[i] = (q[i].size() != 0) && m_free;
    end
    check("in_ready",  bus.in_ready,  m_rdy);
    check("arb_req",   bus.arb_req,   m_req);
    check("arb_en",    bus.arb_en,    |m_req);
    check("out_valid", bus.out_valid, m_valid);
    check("out_data",  bus.out_data,  m_data);
    check("out_src",   bus.out_src,   m_src);
    if (rst_n) begin
      if (m_valid && bus.out_ready) xlog.push_back({m_src, m_data});
      m_acc = bus.arb_gnt & m_req;
      pop_k = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (m_acc[i]) pop_k = i;
      if (pop_k >= 0) begin
        m_data = q[pop_k].pop_front();
        m_src  = src_idx_t'(pop_k);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.in_valid[i] && m_rdy[i]) q[i].push_back(bus.in_data[i*DATA_W +: DATA_W]);
      if (pop_k >= 0) m_valid = 1'b1;
      else if (bus.out_ready) m_valid = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input int src, input logic [DATA_W-1:0] d);
    bus.in_valid[src] = 1'b1;
    bus.in_data[src*DATA_W +: DATA_W] = d;
  endtask

  logic [DATA_W-1:0] exp_seq [8];

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    force_en      = 1'b0;
    force_gnt     = '0;
    step();
    step();
    check("rst_in_ready", bus.in_ready, 4'b1111);
    check("rst_arb_req",  bus.arb_req,  4'b0000);
    check("rst_out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    step();

    // Single source latency
    bus.out_ready = 1'b1;
    set_push(2, 8'hA5);
    step();
    bus.in_valid = '0;
    check("single_arb_req", bus.arb_req, 4'b0100);
    step();
    check("single_valid", bus.out_valid, 1'b1);
    check("single_data",  bus.out_data,  8'hA5);
    check("single_src",   bus.out_src,   2'd2);
    step();
    check("single_drain", bus.out_valid, 1'b0);

    // All four FIFOs full, then drain at full rate
    force_en = 1'b1;
    force_gnt = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_REQ; i++) set_push(i, 8'(16 * (i + 1) + k));
      step();
    end
    bus.in_valid = '0;
    check("fill_in_ready", bus.in_ready, 4'b0000);
    xlog.delete();
    force_en = 1'b0;
    exp_seq = '{8'h40, 8'h10, 8'h20, 8'h30, 8'h41, 8'h11, 8'h21, 8'h31};
    for (int k = 0; k < 8; k++) begin
      step();
      check("burst_valid", bus.out_valid, 1'b1);
      check("burst_data",  bus.out_data,  exp_seq[k]);
    end
    step();
    check("burst_end_valid", bus.out_valid, 1'b0);
    check("burst_count", xlog.size(), 8);
    for (int k = 0; k < 8 && k < xlog.size(); k++)
      check("burst_log", xlog[k][7:0], exp_seq[k]);

    // Backpressure with stray grants while arb_en is low
    bus.out_ready = 1'b0;
    set_push(1, 8'h61);
    step();
    set_push(1, 8'h62);
    step();
    bus.in_valid = '0;
    force_en = 1'b1;
    force_gnt = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      check("stall_arb_req", bus.arb_req,  4'b0000);
      check("stall_data",    bus.out_data, 8'h61);
      check("stall_valid",   bus.out_valid, 1'b1);
      step();
    end
    force_en = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("unstall_arb_req", bus.arb_req, 4'b0010);
    step();
    check("unstall_valid", bus.out_valid, 1'b1);
    check("unstall_data",  bus.out_data,  8'h62);
    check("unstall_src",   bus.out_src,   2'd1);
    step();

    // Full FIFO on src0, rejected push, pop against a full FIFO, push+pop
    force_en = 1'b1;
    force_gnt = '0;
    set_push(0, 8'h11);
    step();
    check("full_rdy1", bus.in_ready, 4'b1111);
    set_push(0, 8'h22);
    step();
    check("full_rdy2", bus.in_ready, 4'b1110);
    set_push(0, 8'h33);
    step();
    check("full_rdy3", bus.in_ready, 4'b1110);
    force_gnt = 4'b0001;
    step();
    check("full_pop_data", bus.out_data, 8'h11);
    check("full_pop_rdy",  bus.in_ready, 4'b1111);
    set_push(0, 8'h44);
    step();
    check("pushpop_data", bus.out_data, 8'h22);
    check("pushpop_rdy",  bus.in_ready, 4'b1111);
    bus.in_valid = '0;
    step();
    check("pushpop_next", bus.out_data, 8'h44);
    force_gnt = '0;
    step();
    check("full_empty_valid", bus.out_valid, 1'b0);
    check("full_empty_req",   bus.arb_req,   4'b0000);

    // Multi-hot and unrequested grant bits
    set_push(0, 8'h77);
    set_push(2, 8'h88);
    step();
    bus.in_valid = '0;
    force_gnt = 4'b0011;
    step();
    check("illegal_data", bus.out_data, 8'h77);
    check("illegal_src",  bus.out_src,  2'd0);
    check("illegal_req",  bus.arb_req,  4'b0100);
    force_gnt = 4'b0010;
    step();
    check("stray_valid", bus.out_valid, 1'b0);
    check("stray_req",   bus.arb_req,   4'b0100);
    force_gnt = 4'b0100;
    step();
    check("stray_next_data", bus.out_data, 8'h88);
    force_gnt = '0;
    step();

    // Reset in the middle of queued traffic and a stalled slot
    bus.out_ready = 1'b0;
    set_push(0, 8'hA0);
    set_push(1, 8'hC0);
    set_push(3, 8'hB0);
    step();
    bus.in_valid = '0;
    set_push(0, 8'hA1);
    step();
    bus.in_valid = '0;
    force_gnt = 4'b0010;
    step();
    force_gnt = '0;
    check("pre_rst_valid", bus.out_valid, 1'b1);
    check("pre_rst_data",  bus.out_data,  8'hC0);
    check("pre_rst_rdy",   bus.in_ready,  4'b1110);
    step();
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_req",   bus.arb_req,   4'b0000);
    check("mid_rst_rdy",   bus.in_ready,  4'b1111);
    check("mid_rst_data",  bus.out_data,  8'h00);
    rst_n = 1'b1;
    force_en = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_valid", bus.out_valid, 1'b0);
      check("post_rst_req",   bus.arb_req,   4'b0000);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
